// File: rtl/apb_reg_slave_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// apb_reg_slave_if : APB3 bus signals between requester and register completer
// Revision 1.0
// -----------------------------------------------------------------------------
interface apb_reg_slave_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface
`default_nettype wire

// File: rtl/apb_reg_slave.sv
`default_nettype none
// -----------------------------------------------------------------------------
// apb_reg_slave : APB3 R/W register bank plus read-only STATUS write counter
// Revision 1.0
// -----------------------------------------------------------------------------
module apb_reg_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 0,
  parameter int          IRQ_THRESH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  apb_reg_slave_if.slave        apb,
  output logic [NUM_REGS*32-1:0] reg_out_o,
  output logic [15:0]           wr_count_o,
  output logic                  irq_o
);

  localparam int               IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int               NUM_RW     = NUM_REGS - 1;
  localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [29:0]      NUM_REGS_W = 30'(NUM_REGS);
  localparam logic [3:0]       WAIT_INIT  = 4'(WAIT_STATES);
  localparam logic [15:0]      THRESH     = 16'(IRQ_THRESH);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t      state_q;
  logic [3:0]  wcnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic [31:0] mem_q [NUM_RW];
  logic [15:0] wr_count_q;
  logic [15:0] wr_count_d;
  logic        irq_q;

  logic [31:0]      off;
  logic             valid;
  logic [IDX_W-1:0] idx;
  logic             is_status;
  logic             done;
  logic             commit;
  logic             mem_we;
  logic [31:0]      rdval;

  // Decode works on the address latched in SETUP, so PADDR may change in ACCESS.
  assign off       = addr_q - BASE_ADDR;
  assign valid     = (off[1:0] == 2'b00) && (off[31:2] < NUM_REGS_W);
  assign idx       = off[IDX_W+1:2];
  assign is_status = (idx == STATUS_IDX);
  assign done      = (state_q == ST_ACCESS) && (wcnt_q == 4'd0) && apb.psel && apb.penable;
  assign commit    = done && write_q && valid;
  assign mem_we    = commit && !is_status;

  always_comb begin
    rdval = 32'h0;
    if (is_status) begin
      rdval = {16'h0, wr_count_q};
    end else begin
      for (int i = 0; i < NUM_RW; i++) begin
        if (idx == IDX_W'(i)) rdval = mem_q[i];
      end
    end
  end

  always_comb begin
    wr_count_d = wr_count_q;
    if (commit) begin
      if (is_status)                   wr_count_d = 16'h0;
      else if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
    end
  end

  assign apb.pready  = done;
  assign apb.pslverr = done && !valid;
  assign apb.prdata  = (done && !write_q && valid) ? rdval : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= 4'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      write_q    <= 1'b0;
      wr_count_q <= 16'h0;
      irq_q      <= 1'b0;
      for (int i = 0; i < NUM_RW; i++) mem_q[i] <= 32'h0;
    end else begin
      wr_count_q <= wr_count_d;
      irq_q      <= (wr_count_d >= THRESH);
      for (int i = 0; i < NUM_RW; i++) begin
        if (mem_we && (idx == IDX_W'(i))) mem_q[i] <= wdata_q;
      end
      case (state_q)
        ST_IDLE: begin
          // PENABLE high without a SETUP phase is ignored.
          if (apb.psel && !apb.penable) begin
            addr_q  <= apb.paddr;
            wdata_q <= apb.pwdata;
            write_q <= apb.pwrite;
            wcnt_q  <= WAIT_INIT;
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!apb.psel) begin
            state_q <= ST_IDLE;
          end else if (apb.penable) begin
            if (wcnt_q != 4'd0) wcnt_q  <= wcnt_q - 4'd1;
            else                state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_RW; i++) begin : g_reg_out
    assign reg_out_o[32*i +: 32] = mem_q[i];
  end
  assign reg_out_o[NUM_REGS*32-1 -: 32] = 32'h0;

  assign wr_count_o = wr_count_q;
  assign irq_o      = irq_q;

endmodule
`default_nettype wire

// File: doc/apb_reg_slave.md
# apb_reg_slave

APB3 completer holding a bank of 32-bit control registers plus one read-only status/counter register. It sits directly downstream of the AXI-to-APB write bridge and consumes its PSEL/PENABLE/PWRITE/PADDR/PWDATA transfers. It also supports reads, wait states and error responses, so the same block serves future read-capable requesters.

## Interface
- BASE_ADDR, 32'h0000_0000: byte address of register 0
- NUM_REGS, 8: total registers (2..64); indices 0..NUM_REGS-2 are R/W, index NUM_REGS-1 is STATUS
- WAIT_STATES, 0: PENABLE cycles inserted before PREADY (0..15); 0 is required when fed by the write bridge, which ignores PREADY
- IRQ_THRESH, 4: wr_count value at which irq asserts (1..65535)

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- PSEL  in  1  APB select
- PENABLE  in  1  APB enable
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  32  byte address
- PWDATA  in  32  write data
- PRDATA  out  32  read data, valid only while PREADY=1
- PREADY  out  1  transfer completes this cycle
- PSLVERR  out  1  error response, valid only while PREADY=1
- reg_out  out  NUM_REGS*32  flattened R/W register contents; register i at bits [32i+31:32i]; STATUS slice reads 0
- wr_count  out  16  saturating count of committed R/W-register writes
- irq  out  1  level interrupt, high while wr_count >= IRQ_THRESH

## Operation
- Decode: off = PADDR - BASE_ADDR, mod 2^32. Valid when off[1:0]==0 and off[31:2] < NUM_REGS; idx = off[31:2]. Decode uses the address captured in SETUP.
- FSM states: IDLE and ACCESS.
  - IDLE: on PSEL=1 and PENABLE=0, capture PADDR, PWRITE and PWDATA, load wcnt=WAIT_STATES and go to ACCESS.
  - ACCESS with PSEL=1 and PENABLE=1: if wcnt!=0, decrement wcnt. If wcnt==0, the transfer completes: commit and return to IDLE.
  - ACCESS with PSEL=0: abort. Return to IDLE with no commit and no counter change.
- PREADY = (state==ACCESS && wcnt==0 && PSEL && PENABLE); combinational from registered state.
- PSLVERR = PREADY && !valid.
- PRDATA = PREADY && !write && valid ? rdval : 0, where rdval is mem[idx] for R/W registers and {16'h0, wr_count} for STATUS.
- Commit rules:
  - Valid write to a R/W register: mem[idx] <= data. wr_count increments unless already 16'hFFFF (saturates).
  - Write to STATUS: wr_count <= 0 whatever the data. No PSLVERR. Does not count as a write.
  - Invalid address (misaligned or out of range): no register or counter change. PSLVERR=1. For reads, PRDATA=0.
  - Reads never change state.
- irq = (wr_count >= IRQ_THRESH), registered with wr_count. It drops in the cycle after a STATUS write commits.
- Back-to-back transfers: a new SETUP in the cycle after completion is accepted. No idle cycle is required.
- PENABLE=1 while in IDLE is a protocol violation. It is ignored and the FSM stays in IDLE.

## Timing
- All outputs are low or 0 during and after reset: PREADY, PSLVERR, PRDATA, irq, wr_count, all mem[] and reg_out.
- Reset asserted mid-transfer returns the FSM to IDLE immediately. The pending write is discarded.
- Latency with WAIT_STATES=N:
  - PREADY is high in ACCESS cycle N+1, counting the first PENABLE cycle as 1.
  - The write is visible on reg_out and wr_count on the clock edge that ends the PREADY cycle.
- With N=0:
  - The bridge's SETUP → ACCESS → WAIT_DONE sequence (PSEL high 2 cycles, PENABLE high 1 cycle) completes in exactly one PENABLE cycle.
  - One register update per bridge beat.
- Four-beat bridge burst from address A: mem[A..A+12] updated on 4 successive completions; wr_count +4.

## Test plan
- Reset, then with N=0 write 0xDEADBEEF to BASE+0x4, then read BASE+0x4:
  - reg_out[63:32] = 0xDEADBEEF one edge after PREADY.
  - Read returns 0xDEADBEEF with PSLVERR=0.
  - wr_count = 1.
- Four-beat bridge burst at BASE+0x0 with data 1,2,3,4:
  - mem[0..3] = 1..4 and wr_count = 4.
  - irq rises one cycle after the fourth commit.
  - Write 0 to STATUS (BASE+0x1C) → wr_count = 0, irq falls next cycle.
- WAIT_STATES=3, read STATUS:
  - PREADY stays low for 3 PENABLE cycles and is high on the 4th.
  - PRDATA = {16'h0, wr_count} only in that cycle; 0 otherwise.
- Error cases:
  - Write to BASE+0x20 (out of range) → PSLVERR=1, no reg or wr_count change.
  - Write to BASE+0x2 (misaligned) → PSLVERR=1, no change.
  - Read of BASE+0x20 → PRDATA=0, PSLVERR=1.
- Abort and reset:
  - PSEL dropped in ACCESS with WAIT_STATES=2 → FSM returns to IDLE, no write.
  - rst_n pulsed mid-ACCESS → all outputs 0 and the next transfer works normally.
- Saturation: preload via 65535 writes (or force wr_count=16'hFFFF), then one more write → wr_count stays 16'hFFFF and irq stays 1.
